// File: rtl/bus_arbiter_if.sv
// Handshake bundle between the requesters and the round-robin bus arbiter.
// The master side drives requests and done; the slave side (the arbiter) drives grants.
interface bus_arbiter_if;
  logic [9:0] req;
  logic       done;
  logic [9:0] grant;
  logic [9:0] bus_sel;
  logic [3:0] owner;
  logic       busy;
  logic       timeout;

  modport master (
    output req, done,
    input  grant, bus_sel, owner, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, bus_sel, owner, busy, timeout
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the 10:1 datapath bus mux; drives mux selects directly.
// Optional ownership watchdog enabled by defining BUS_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | bus free, arbitrating among pending requests from ptr
// OWN   | one requester owns the bus until done, req drop or watchdog
// REL   | single dead cycle with all selects low before re-arbitrating
module bus_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 5
) (
  input logic       clk,
  input logic       rst,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN, REL} state_t;

  localparam logic [3:0] NO_OWNER = 4'd15;

  if ((2 ** CW) <= MAX_HOLD) begin : g_cw_check
    $error("bus_arbiter: CW too narrow for MAX_HOLD");
  end

  state_t     state;
  logic [3:0] ptr;
  logic [9:0] grant_r;
  logic [9:0] sel_r;
  logic [3:0] owner_r;
  logic       busy_r;
  logic       timeout_r;

  logic       win_vld;
  logic [3:0] win_idx;

  // Mux encoding: req0 on bit 8, req1..8 shifted down one, req9 stays on bit 9.
  function automatic logic [9:0] sel_of(input logic [3:0] idx);
    logic [9:0] s;
    s = '0;
    case (idx)
      4'd0:    s = 10'h100;
      4'd9:    s = 10'h200;
      default: s = 10'(1) << (idx - 4'd1);
    endcase
    return s;
  endfunction

  // Iterate from the farthest offset down so the closest set bit to ptr wins.
  always_comb begin
    int j;
    win_vld = 1'b0;
    win_idx = 4'd0;
    j = 0;
    for (int i = 9; i >= 0; i--) begin
      j = (int'(ptr) + i) % 10;
      if (bus.req[j]) begin
        win_vld = 1'b1;
        win_idx = 4'(j);
      end
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [CW-1:0] wdog;
  localparam logic [CW-1:0] WDOG_LIMIT = CW'(MAX_HOLD - 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 4'd0;
      grant_r   <= '0;
      sel_r     <= '0;
      owner_r   <= NO_OWNER;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
      wdog      <= '0;
`endif
    end else begin
      timeout_r <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            state   <= OWN;
            grant_r <= 10'(1) << win_idx;
            sel_r   <= sel_of(win_idx);
            owner_r <= win_idx;
            busy_r  <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
            wdog    <= '0;
`endif
          end
        end
        OWN: begin
          if (bus.done || !bus.req[owner_r]) begin
            state   <= REL;
            ptr     <= (owner_r == 4'd9) ? 4'd0 : owner_r + 4'd1;
            grant_r <= '0;
            sel_r   <= '0;
            owner_r <= NO_OWNER;
            busy_r  <= 1'b0;
          end
`ifdef BUS_ARB_TIMEOUT_EN
          else if (wdog == WDOG_LIMIT) begin
            state     <= REL;
            ptr       <= (owner_r == 4'd9) ? 4'd0 : owner_r + 4'd1;
            grant_r   <= '0;
            sel_r     <= '0;
            owner_r   <= NO_OWNER;
            busy_r    <= 1'b0;
            timeout_r <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        REL: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          grant_r <= '0;
          sel_r   <= '0;
          owner_r <= NO_OWNER;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant   = grant_r;
  assign bus.bus_sel = sel_r;
  assign bus.owner   = owner_r;
  assign bus.busy    = busy_r;
  assign bus.timeout = timeout_r;

endmodule
